// File: rtl/id_pipe_stage.sv
// LEGv8 pipelined decode stage: register file with writeback bypass, immediate
// extraction and a valid/ready ID/EX register. Optional load-use stall: ID_HAZARD_EN.
module id_pipe_stage #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int LINK_REG  = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_SIZE-1:0] inst,
    input  logic                 Reg2Loc,
    input  logic                 WRegLoc,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [4:0]           wb_reg,
    input  logic [WORD-1:0]      wb_data,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      out_r_data1,
    output logic [WORD-1:0]      out_r_data2,
    output logic [WORD-1:0]      out_ex_data,
    output logic [4:0]           out_rn,
    output logic [4:0]           out_rm,
    output logic [4:0]           out_rd
);

    localparam logic [4:0] XZR = 5'd31;

    logic [WORD-1:0] regs [32];
    logic [4:0]      rn, rm, rd;
    logic [WORD-1:0] r_data1, r_data2, ex_data;
    logic            hazard;
    logic            xfer;

    assign rn = inst[9:5];
    assign rm = Reg2Loc ? inst[4:0] : inst[20:16];
    assign rd = WRegLoc ? 5'(LINK_REG) : inst[4:0];

    // XZR reads zero; a same-cycle writeback to the read index is forwarded.
    always_comb begin
        r_data1 = regs[rn];
        if (rn == XZR)
            r_data1 = '0;
        else if (wb_en && (wb_reg == rn))
            r_data1 = wb_data;
    end

    always_comb begin
        r_data2 = regs[rm];
        if (rm == XZR)
            r_data2 = '0;
        else if (wb_en && (wb_reg == rm))
            r_data2 = wb_data;
    end

    always_comb begin
        ex_data = '0;
        if ((inst[31:26] == 6'b000101) || (inst[31:26] == 6'b100101))
            ex_data = {{(WORD-26){inst[25]}}, inst[25:0]};
        else if ((inst[31:24] == 8'b10110100) || (inst[31:24] == 8'b10110101))
            ex_data = {{(WORD-19){inst[23]}}, inst[23:5]};
        else if ((inst[31:21] == 11'b11111000010) || (inst[31:21] == 11'b11111000000))
            ex_data = {{(WORD-9){inst[20]}}, inst[20:12]};
        else if ((inst[31:22] == 10'b1001000100) || (inst[31:22] == 10'b1101000100))
            ex_data = {{(WORD-12){1'b0}}, inst[21:10]};
    end

`ifdef ID_HAZARD_EN
    assign hazard = in_valid & ex_mem_read & (ex_rd != XZR) & ((ex_rd == rn) | (ex_rd == rm));
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{ex_mem_read, ex_rd};
    assign hazard = 1'b0;
`endif

    // Handshake: a transfer occurs on a rising edge where in_valid && in_ready;
    // the producer must hold inst stable until then. out_valid qualifies all
    // outputs and stays high until EX samples it with out_ready.
    assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_r_data1 <= '0;
            out_r_data2 <= '0;
            out_ex_data <= '0;
            out_rn      <= '0;
            out_rm      <= '0;
            out_rd      <= '0;
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else begin
            if (wb_en && (wb_reg != XZR))
                regs[wb_reg] <= wb_data;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                out_valid   <= 1'b1;
                out_r_data1 <= r_data1;
                out_r_data2 <= r_data2;
                out_ex_data <= ex_data;
                out_rn      <= rn;
                out_rm      <= rm;
                out_rd      <= rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_id_pipe_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        Reg2Loc;
    logic        WRegLoc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_r_data1, out_r_data2, out_ex_data;
    logic [4:0]  out_rn, out_rm, out_rd;

    int checks = 0;
    int errors = 0;

    id_pipe_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .Reg2Loc(Reg2Loc), .WRegLoc(WRegLoc), .flush(flush), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_r_data1(out_r_data1),
        .out_r_data2(out_r_data2), .out_ex_data(out_ex_data), .out_rn(out_rn),
        .out_rm(out_rm), .out_rd(out_rd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_regs [32];
    logic        m_init = 1'b0;
    logic        m_valid;
    logic [63:0] m_r1, m_r2, m_ex;
    logic [4:0]  m_rn, m_rm, m_rd;

    function automatic logic [63:0] m_read(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (wb_en && wb_reg == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] i);
        longint v;
        v = 0;
        if (i[31:26] == 6'b000101 || i[31:26] == 6'b100101)
            v = (i[25] ? longint'(i[25:0]) - (longint'(1) << 26) : longint'(i[25:0]));
        else if (i[31:24] == 8'b10110100 || i[31:24] == 8'b10110101)
            v = (i[23] ? longint'(i[23:5]) - (longint'(1) << 19) : longint'(i[23:5]));
        else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000)
            v = (i[20] ? longint'(i[20:12]) - (longint'(1) << 9) : longint'(i[20:12]));
        else if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100)
            v = longint'(i[21:10]);
        return 64'(v);
    endfunction

    function automatic logic [4:0] m_rm_idx(input logic [31:0] i, input logic sel);
        return sel ? i[4:0] : i[20:16];
    endfunction

    function automatic logic m_hazard(input logic [31:0] i, input logic sel);
`ifdef ID_HAZARD_EN
        return in_valid && ex_mem_read && ex_rd != 5'd31 &&
               (ex_rd == i[9:5] || ex_rd == m_rm_idx(i, sel));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_in_ready();
        return (!m_valid || out_ready) && !m_hazard(inst, Reg2Loc) && !flush;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_valid <= 1'b0;
            m_r1 <= 64'd0; m_r2 <= 64'd0; m_ex <= 64'd0;
            m_rn <= 5'd0;  m_rm <= 5'd0;  m_rd <= 5'd0;
            for (int i = 0; i < 32; i++) m_regs[i] <= 64'd0;
        end else begin
            if (wb_en && wb_reg != 5'd31) m_regs[wb_reg] <= wb_data;
            if (flush) begin
                m_valid <= 1'b0;
            end else if (in_valid && m_in_ready()) begin
                m_valid <= 1'b1;
                m_r1 <= m_read(inst[9:5]);
                m_r2 <= m_read(m_rm_idx(inst, Reg2Loc));
                m_ex <= m_imm(inst);
                m_rn <= inst[9:5];
                m_rm <= m_rm_idx(inst, Reg2Loc);
                m_rd <= WRegLoc ? 5'd30 : inst[4:0];
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            chk("m_in_ready", {63'd0, in_ready}, {63'd0, m_in_ready()});
            chk("m_r_data1", out_r_data1, m_r1);
            chk("m_r_data2", out_r_data2, m_r2);
            chk("m_ex_data", out_ex_data, m_ex);
            chk("m_rn", {59'd0, out_rn}, {59'd0, m_rn});
            chk("m_rm", {59'd0, out_rm}, {59'd0, m_rm});
            chk("m_rd", {59'd0, out_rd}, {59'd0, m_rd});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        ex_mem_read = 1'b0; ex_rd = 5'd0; Reg2Loc = 1'b0; WRegLoc = 1'b0;
    endtask

    function automatic logic [31:0] add_i(input logic [4:0] d, input logic [4:0] n, input logic [4:0] m);
        return {11'b10001011000, m, 6'd0, n, d};
    endfunction

    function automatic logic [31:0] addi_i(input logic [11:0] imm);
        return {10'b1001000100, imm, 5'd1, 5'd2};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: r[31:26] = $urandom_range(0, 1) ? 6'b000101 : 6'b100101;
            1: r[31:24] = $urandom_range(0, 1) ? 8'b10110100 : 8'b10110101;
            2: r[31:21] = $urandom_range(0, 1) ? 11'b11111000010 : 11'b11111000000;
            3: r[31:22] = $urandom_range(0, 1) ? 10'b1001000100 : 10'b1101000100;
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; inst = 32'd0; wb_reg = 5'd0; wb_data = 64'd0;
        idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_r_data1", out_r_data1, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h1234;
        tick(); idle();
        in_valid = 1'b1; inst = add_i(5'd1, 5'd5, 5'd5);
        tick(); idle();
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_r1", out_r_data1, 64'h1234);
        chk("add_r2", out_r_data2, 64'h1234);
        chk("add_rd", {59'd0, out_rd}, 64'd1);

        in_valid = 1'b1; inst = add_i(5'd2, 5'd7, 5'd31);
        wb_en = 1'b1; wb_reg = 5'd7; wb_data = 64'hABCD;
        tick(); idle();
        chk("bypass_r1", out_r_data1, 64'hABCD);
        chk("xzr_r2", out_r_data2, 64'd0);

        wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'hDEAD;
        tick(); idle();
        in_valid = 1'b1; inst = add_i(5'd3, 5'd31, 5'd31);
        tick();
        chk("xzr_write_r1", out_r_data1, 64'd0);

        inst = {11'b11111000010, 9'h1FF, 2'b00, 5'd5, 5'd4};
        tick();
        chk("ldur_imm", out_ex_data, 64'hFFFF_FFFF_FFFF_FFFF);
        inst = addi_i(12'hFFF);
        tick();
        chk("addi_imm", out_ex_data, 64'h0000_0000_0000_0FFF);
        inst = {6'b000101, 26'h2000000};
        tick();
        chk("b_imm", out_ex_data, 64'hFFFF_FFFF_FE00_0000);
        inst = {8'b10110100, 19'h12345, 5'd3};
        tick();
        chk("cbz_imm", out_ex_data, 64'h0000_0000_0001_2345);
        inst = {6'b100101, 26'd4}; WRegLoc = 1'b1;
        tick(); WRegLoc = 1'b0;
        chk("bl_rd", {59'd0, out_rd}, 64'd30);
        chk("bl_imm", out_ex_data, 64'd4);

        inst = addi_i(12'h123); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_imm", out_ex_data, 64'd4);
        end
        out_ready = 1'b1;
        tick(); idle();
        chk("bp_release_imm", out_ex_data, 64'h123);
        chk("bp_release_valid", {63'd0, out_valid}, 64'd1);
        tick();
        chk("bubble_valid", {63'd0, out_valid}, 64'd0);
        chk("bubble_hold", out_ex_data, 64'h123);

        in_valid = 1'b1; inst = addi_i(12'h055);
        tick();
        inst = addi_i(12'h077); flush = 1'b1;
        #1;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick(); idle();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_not_latched", out_ex_data, 64'h055);

`ifdef ID_HAZARD_EN
        in_valid = 1'b1; inst = addi_i(12'h011);
        tick();
        inst = add_i(5'd1, 5'd5, 5'd6); ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        chk("hz_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("hz_bubble", {63'd0, out_valid}, 64'd0);
        ex_mem_read = 1'b0;
        #1;
        chk("hz_clear_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("hz_accept_valid", {63'd0, out_valid}, 64'd1);
        chk("hz_accept_rn", {59'd0, out_rn}, 64'd5);
        inst = add_i(5'd1, 5'd31, 5'd31); ex_mem_read = 1'b1; ex_rd = 5'd31;
        #1;
        chk("hz_xzr_ready", {63'd0, in_ready}, 64'd1);
        tick(); idle();
`else
        in_valid = 1'b1; inst = add_i(5'd1, 5'd5, 5'd6); ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        chk("nohz_in_ready", {63'd0, in_ready}, 64'd1);
        tick(); idle();
        chk("nohz_valid", {63'd0, out_valid}, 64'd1);
`endif

        in_valid = 1'b1; inst = addi_i(12'h099);
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; idle();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_imm", out_ex_data, 64'd0);
        chk("midrst_rd", {59'd0, out_rd}, 64'd0);
        in_valid = 1'b1; inst = add_i(5'd1, 5'd5, 5'd5);
        tick(); idle();
        chk("midrst_regfile", out_r_data1, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            inst        = rand_inst();
            Reg2Loc     = $urandom_range(0, 1);
            WRegLoc     = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            wb_en       = $urandom_range(0, 1);
            wb_reg      = $urandom_range(0, 1) ? inst[9:5] : 5'($urandom_range(0, 31));
            wb_data     = {$urandom(), $urandom()};
            out_ready   = ($urandom_range(0, 9) < 7);
            ex_mem_read = ($urandom_range(0, 9) < 3);
            ex_rd       = $urandom_range(0, 1) ? inst[9:5] : 5'($urandom_range(0, 31));
            tick();
        end
        rst = 1'b0; idle();
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
